ring_decoder: RTL and testbench

RING_DECODER -- requirements
Module: ring_decoder

---
 rtl/ring_decoder.sv | 187 ++++++++++++++++++
 tb/tb_ring_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
// Ring-counter sequence decoder: tracks a 4-state Johnson-style code ring and reports lock/errors.
// Latency: 1 cycle; every output is registered and reflects the code accepted at the prior edge.
// Backpressure: none; code_in is sampled only when code_valid is high and the block is always ready.
//
// Ports:
//   clk         - sole clock, rising edge
//   reset       - asynchronous active-low reset
//   clr         - synchronous clear of rev_cnt, err_cnt and lock state (beats code_valid)
//   code_in     - ring counter state word, bit 2 = first stage
//   code_valid  - qualifies code_in
//   phase       - decoded phase of the last legal accepted code
//   locked      - high while tracking a correct sequence
//   illegal_err - one-cycle pulse on an illegal accepted code
//   seq_err     - one-cycle pulse on an out-of-order legal code while locked
//   rev_cnt     - completed revolutions while locked (wraps)
//   err_cnt     - total error pulses (saturates)
module ring_decoder #(
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  output logic [1:0] phase,
  output logic       locked,
  output logic       illegal_err,
  output logic       seq_err,
  output logic [7:0] rev_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] good_q, good_d;
  logic       locked_q, locked_d;
  logic       illegal_q, illegal_d;
  logic       seq_q, seq_d;
  logic [7:0] rev_q, rev_d;
  logic [7:0] err_q, err_d;

  logic       code_legal;
  logic [1:0] code_phase;
  logic [1:0] exp_phase;
  logic       code_exp;
  logic [3:0] good_inc;

  // Code decode: only the four ring states are legal.
  always_comb begin
    code_legal = 1'b1;
    code_phase = 2'd0;
    case (code_in)
      3'b001:  code_phase = 2'd0;
      3'b100:  code_phase = 2'd1;
      3'b110:  code_phase = 2'd2;
      3'b011:  code_phase = 2'd3;
      default: code_legal = 1'b0;
    endcase
  end

  // A repeated code is not the expected successor, so it counts as out of order.
  assign exp_phase = phase_q + 2'd1;
  assign code_exp  = code_legal && (code_phase == exp_phase);
  assign good_inc  = good_q + 4'd1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = HUNT;
    end else if (code_valid) begin
      case (state_q)
        HUNT: begin
          if (code_legal) state_d = SYNC;
        end
        SYNC: begin
          if (!code_legal) begin
            state_d = HUNT;
          end else if (code_exp && (good_inc == LOCK_CNT_W)) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (!code_legal) begin
            state_d = HUNT;
          end else if (!code_exp) begin
            state_d = SYNC;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    phase_d   = phase_q;
    good_d    = good_q;
    illegal_d = 1'b0;
    seq_d     = 1'b0;
    rev_d     = rev_q;
    err_d     = err_q;

    if (clr) begin
      // Phase deliberately held; only lock state and counters are cleared.
      good_d = 4'd0;
      rev_d  = 8'd0;
      err_d  = 8'd0;
    end else if (code_valid) begin
      if (!code_legal) begin
        illegal_d = 1'b1;
        good_d    = 4'd0;
      end else begin
        phase_d = code_phase;
        case (state_q)
          SYNC: begin
            good_d = code_exp ? good_inc : 4'd0;
          end
          LOCKED: begin
            if (code_exp) begin
              // Wrapping 3->0 completes one revolution.
              if (phase_q == 2'd3) rev_d = rev_q + 8'd1;
            end else begin
              seq_d  = 1'b1;
              good_d = 4'd0;
            end
          end
          default: begin
            good_d = 4'd0;
          end
        endcase
      end

      // At most one of the two pulses is set, so one increment covers both.
      if ((illegal_d || seq_d) && (err_q != 8'hFF)) begin
        err_d = err_q + 8'd1;
      end
    end
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= 2'd0;
      good_q    <= 4'd0;
      locked_q  <= 1'b0;
      illegal_q <= 1'b0;
      seq_q     <= 1'b0;
      rev_q     <= 8'd0;
      err_q     <= 8'd0;
    end else begin
      phase_q   <= phase_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      illegal_q <= illegal_d;
      seq_q     <= seq_d;
      rev_q     <= rev_d;
      err_q     <= err_d;
    end
  end

  assign phase       = phase_q;
  assign locked      = locked_q;
  assign illegal_err = illegal_q;
  assign seq_err     = seq_q;
  assign rev_cnt     = rev_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_ring_decoder.sv
module tb_ring_decoder;

  logic       clk;
  logic       reset;
  logic       clr;
  logic [2:0] code_in;
  logic       code_valid;
  logic [1:0] phase;
  logic       locked;
  logic       illegal_err;
  logic       seq_err;
  logic [7:0] rev_cnt;
  logic [7:0] err_cnt;

  int checks = 0;
  int passed = 0;

  ring_decoder #(.LOCK_CNT(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .phase       (phase),
    .locked      (locked),
    .illegal_err (illegal_err),
    .seq_err     (seq_err),
    .rev_cnt     (rev_cnt),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, let one rising edge pass, then settle 1ns for sampling.
  task automatic apply(input logic [2:0] code, input logic valid);
    @(negedge clk);
    code_in    = code;
    code_valid = valid;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; clr = 1'b0; code_in = 3'b000; code_valid = 1'b0;
    #12;
    checks++; if ({phase, locked, illegal_err, seq_err} !== 5'b0) $display("FAIL reset_flags: got phase=%0d lk=%b ie=%b se=%b want all 0", phase, locked, illegal_err, seq_err); else passed++;
    checks++; if ({rev_cnt, err_cnt} !== 16'h0) $display("FAIL reset_cnts: got rev=%0d err=%0d want 0 0", rev_cnt, err_cnt); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lock;
    apply(3'b001, 1'b1);
    checks++; if (phase !== 2'd0 || locked !== 1'b0) $display("FAIL lock_first: got phase=%0d lk=%b want 0 0", phase, locked); else passed++;
    apply(3'b100, 1'b1);
    apply(3'b110, 1'b1);
    checks++; if (locked !== 1'b0) $display("FAIL lock_early: got lk=%b want 0", locked); else passed++;
    apply(3'b011, 1'b1);
    checks++; if (locked !== 1'b1 || phase !== 2'd3) $display("FAIL lock_done: got lk=%b phase=%0d want 1 3", locked, phase); else passed++;
    checks++; if (err_cnt !== 8'd0 || rev_cnt !== 8'd0) $display("FAIL lock_cnts: got err=%0d rev=%0d want 0 0", err_cnt, rev_cnt); else passed++;
  endtask

  task automatic test_revolutions;
    apply(3'b001, 1'b1);
    checks++; if (rev_cnt !== 8'd1 || phase !== 2'd0) $display("FAIL rev_first: got rev=%0d phase=%0d want 1 0", rev_cnt, phase); else passed++;
    apply(3'b100, 1'b1);
    apply(3'b110, 1'b1);
    apply(3'b011, 1'b1);
    checks++; if (rev_cnt !== 8'd1) $display("FAIL rev_hold: got rev=%0d want 1", rev_cnt); else passed++;
    apply(3'b001, 1'b1);
    checks++; if (rev_cnt !== 8'd2) $display("FAIL rev_second: got rev=%0d want 2", rev_cnt); else passed++;
    for (int i = 0; i < 254; i++) begin
      apply(3'b100, 1'b1);
      apply(3'b110, 1'b1);
      apply(3'b011, 1'b1);
      apply(3'b001, 1'b1);
    end
    checks++; if (rev_cnt !== 8'd0 || locked !== 1'b1 || err_cnt !== 8'd0) $display("FAIL rev_wrap: got rev=%0d lk=%b err=%0d want 0 1 0", rev_cnt, locked, err_cnt); else passed++;
  endtask

  task automatic test_seq_err;
    apply(3'b100, 1'b1);
    apply(3'b011, 1'b1);
    checks++; if (seq_err !== 1'b1 || illegal_err !== 1'b0) $display("FAIL seq_pulse: got se=%b ie=%b want 1 0", seq_err, illegal_err); else passed++;
    checks++; if (locked !== 1'b0 || phase !== 2'd3 || err_cnt !== 8'd1) $display("FAIL seq_state: got lk=%b phase=%0d err=%0d want 0 3 1", locked, phase, err_cnt); else passed++;
    apply(3'b001, 1'b1);
    checks++; if (seq_err !== 1'b0 || locked !== 1'b0) $display("FAIL seq_one_cycle: got se=%b lk=%b want 0 0", seq_err, locked); else passed++;
    apply(3'b100, 1'b1);
    apply(3'b110, 1'b1);
    checks++; if (locked !== 1'b1 || phase !== 2'd2 || rev_cnt !== 8'd0) $display("FAIL seq_relock: got lk=%b phase=%0d rev=%0d want 1 2 0", locked, phase, rev_cnt); else passed++;
  endtask

  task automatic test_illegal_and_hold;
    apply(3'b101, 1'b1);
    checks++; if (illegal_err !== 1'b1 || seq_err !== 1'b0 || locked !== 1'b0) $display("FAIL ill_pulse: got ie=%b se=%b lk=%b want 1 0 0", illegal_err, seq_err, locked); else passed++;
    checks++; if (phase !== 2'd2 || err_cnt !== 8'd2) $display("FAIL ill_state: got phase=%0d err=%0d want 2 2", phase, err_cnt); else passed++;
    apply(3'b111, 1'b0);
    checks++; if (illegal_err !== 1'b0 || phase !== 2'd2 || err_cnt !== 8'd2 || locked !== 1'b0) $display("FAIL hold_invalid: got ie=%b phase=%0d err=%0d lk=%b want 0 2 2 0", illegal_err, phase, err_cnt, locked); else passed++;
    // From HUNT, a full 4-code run is needed to lock again.
    apply(3'b001, 1'b1);
    apply(3'b100, 1'b1);
    apply(3'b110, 1'b1);
    checks++; if (locked !== 1'b0) $display("FAIL hunt_not_locked: got lk=%b want 0", locked); else passed++;
    apply(3'b011, 1'b1);
    checks++; if (locked !== 1'b1) $display("FAIL hunt_relock: got lk=%b want 1", locked); else passed++;
  endtask

  task automatic test_clr;
    for (int i = 0; i < 5; i++) begin
      apply(3'b001, 1'b1);
      apply(3'b100, 1'b1);
      apply(3'b110, 1'b1);
      apply(3'b011, 1'b1);
    end
    checks++; if (rev_cnt !== 8'd5 || err_cnt !== 8'd2 || locked !== 1'b1) $display("FAIL clr_pre: got rev=%0d err=%0d lk=%b want 5 2 1", rev_cnt, err_cnt, locked); else passed++;
    @(negedge clk);
    clr = 1'b1;
    apply(3'b001, 1'b1);
    checks++; if (rev_cnt !== 8'd0 || err_cnt !== 8'd0 || locked !== 1'b0) $display("FAIL clr_cnts: got rev=%0d err=%0d lk=%b want 0 0 0", rev_cnt, err_cnt, locked); else passed++;
    checks++; if (illegal_err !== 1'b0 || seq_err !== 1'b0 || phase !== 2'd3) $display("FAIL clr_pulse: got ie=%b se=%b phase=%0d want 0 0 3", illegal_err, seq_err, phase); else passed++;
    @(negedge clk);
    clr = 1'b0;
    apply(3'b001, 1'b1);
    apply(3'b100, 1'b1);
    apply(3'b110, 1'b1);
    checks++; if (locked !== 1'b0) $display("FAIL clr_hunt: got lk=%b want 0", locked); else passed++;
    apply(3'b011, 1'b1);
    checks++; if (locked !== 1'b1 || phase !== 2'd3) $display("FAIL clr_relock: got lk=%b phase=%0d want 1 3", locked, phase); else passed++;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({phase, locked, illegal_err, seq_err} !== 5'b0 || {rev_cnt, err_cnt} !== 16'h0) $display("FAIL async_reset: got phase=%0d lk=%b ie=%b se=%b rev=%0d err=%0d want all 0", phase, locked, illegal_err, seq_err, rev_cnt, err_cnt); else passed++;
    @(negedge clk);
    reset = 1'b1;
    apply(3'b100, 1'b1);
    checks++; if (phase !== 2'd1 || locked !== 1'b0) $display("FAIL post_reset_hunt: got phase=%0d lk=%b want 1 0", phase, locked); else passed++;
    apply(3'b110, 1'b1);
    apply(3'b011, 1'b1);
    apply(3'b001, 1'b1);
    checks++; if (locked !== 1'b1 || rev_cnt !== 8'd0 || phase !== 2'd0) $display("FAIL post_reset_lock: got lk=%b rev=%0d phase=%0d want 1 0 0", locked, rev_cnt, phase); else passed++;
  endtask

  task automatic test_err_saturate;
    for (int i = 0; i < 300; i++) begin
      apply(3'b000, 1'b1);
      if (i == 254) begin
        checks++; if (err_cnt !== 8'd255) $display("FAIL sat_reach: got err=%0d want 255", err_cnt); else passed++;
      end
    end
    checks++; if (err_cnt !== 8'd255 || illegal_err !== 1'b1 || locked !== 1'b0) $display("FAIL sat_hold: got err=%0d ie=%b lk=%b want 255 1 0", err_cnt, illegal_err, locked); else passed++;
    apply(3'b000, 1'b0);
    checks++; if (illegal_err !== 1'b0 || err_cnt !== 8'd255) $display("FAIL sat_idle: got ie=%b err=%0d want 0 255", illegal_err, err_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_revolutions();
    test_seq_err();
    test_illegal_and_hold();
    test_clr();
    test_async_reset();
    test_err_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
